// File: rtl/dspi_nor_reader.sv
// rtl/dspi_nor_reader.sv - dual-I/O (2-2-2) SPI NOR fast-read initiator returning one 32-bit word per request
//
// Ports:
//   clk, rst           system clock, asynchronous active-high reset
//   rd_req, rd_addr    request handshake and 24-bit byte address (sampled on accept)
//   rd_ready           high only while idle; accept = rd_req & rd_ready
//   rd_valid, rd_data  one-cycle completion pulse and little-endian word (byte@addr in [7:0])
//   sck, csb           SPI clock (mode 0, idles low) and active-low chip select
//   dio_o, dio_oe      2-bit data and per-bit output enable towards the pads
//   dio_i              2-bit data from the pads
module dspi_nor_reader #(
    parameter int         SCK_HALF = 2,
    parameter logic [7:0] CMD      = 8'hBB,
    parameter int         DUMMY    = 8,
    parameter int         CSB_IDLE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_req,
    input  logic [23:0] rd_addr,
    output logic        rd_ready,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        sck,
    output logic        csb,
    output logic [1:0]  dio_o,
    output logic [1:0]  dio_oe,
    input  logic [1:0]  dio_i
);

    // Rising-edge milestones, counted as "rising edges completed so far".
    localparam logic [15:0] HALF_M1   = 16'(SCK_HALF - 1);
    localparam logic [8:0]  CMD_END   = 9'd4;
    localparam logic [8:0]  ADDR_END  = 9'd16;
    localparam logic [8:0]  DUMMY_END = 9'(16 + DUMMY);
    localparam logic [8:0]  LAST_RISE = 9'(32 + DUMMY);
    // GAP is left early enough that the next csb fall lands CSB_IDLE+1 clks
    // after csb rose (one clk of IDLE for the accept, one for the csb fall).
    localparam logic [15:0] GAP_LAST  = (CSB_IDLE >= 2) ? 16'(CSB_IDLE - 2) : 16'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DUMMY,
        S_DATA,
        S_GAP
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] hcnt_q, hcnt_d;
    logic [8:0]  rise_cnt_q, rise_cnt_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic [31:0] sr_q, sr_d;
    logic        sck_q, sck_d;
    logic        csb_q, csb_d;
    logic [1:0]  dio_o_q, dio_o_d;
    logic [1:0]  dio_oe_q, dio_oe_d;
    logic        rd_valid_q, rd_valid_d;
    logic [31:0] rd_data_q, rd_data_d;

    logic accept;
    logic tick;
    logic sck_rise;
    logic sck_fall;
    logic gap_done;

    assign accept   = rd_req && (state_q == S_IDLE);
    // The half-period counter only runs once csb is low.
    assign tick     = !csb_q && (hcnt_q == HALF_M1);
    assign sck_rise = tick && !sck_q;
    assign sck_fall = tick && sck_q;
    assign gap_done = (gap_cnt_q >= GAP_LAST);

    assign rd_ready = (state_q == S_IDLE);
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign sck      = sck_q;
    assign csb      = csb_q;
    assign dio_o    = dio_o_q;
    assign dio_oe   = dio_oe_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: phase changes happen on sck falling edges.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_CMD;
            S_CMD:   if (sck_fall && rise_cnt_q == CMD_END) state_d = S_ADDR;
            S_ADDR:  if (sck_fall && rise_cnt_q == ADDR_END) state_d = (DUMMY == 0) ? S_DATA : S_DUMMY;
            S_DUMMY: if (sck_fall && rise_cnt_q == DUMMY_END) state_d = S_DATA;
            S_DATA:  if (sck_fall && rise_cnt_q == LAST_RISE) state_d = S_GAP;
            S_GAP:   if (gap_done) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        hcnt_d     = hcnt_q;
        rise_cnt_d = rise_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        sr_d       = sr_q;
        sck_d      = sck_q;
        csb_d      = csb_q;
        dio_o_d    = dio_o_q;
        dio_oe_d   = dio_oe_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    // One shift register carries command+address out and data in.
                    sr_d       = {CMD, rd_addr};
                    rise_cnt_d = '0;
                    hcnt_d     = '0;
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q + 16'd1;
            end
            S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
                if (csb_q) begin
                    // First clk after accept: drop csb and present CMD[7:6].
                    csb_d    = 1'b0;
                    dio_oe_d = 2'b11;
                    dio_o_d  = sr_q[31:30];
                    sr_d     = {sr_q[29:0], 2'b00};
                    hcnt_d   = '0;
                end else begin
                    hcnt_d = tick ? 16'd0 : hcnt_q + 16'd1;
                    if (sck_rise) begin
                        sck_d      = 1'b1;
                        rise_cnt_d = rise_cnt_q + 9'd1;
                        if (state_q == S_DATA) begin
                            sr_d = {sr_q[29:0], dio_i};
                        end
                    end
                    if (sck_fall) begin
                        sck_d = 1'b0;
                        if (rise_cnt_q < ADDR_END) begin
                            dio_o_d = sr_q[31:30];
                            sr_d    = {sr_q[29:0], 2'b00};
                        end else if (rise_cnt_q == ADDR_END) begin
                            // Bus turnaround: release the pads until the next transaction.
                            dio_oe_d = 2'b00;
                            dio_o_d  = 2'b00;
                        end
                        if (rise_cnt_q == LAST_RISE) begin
                            // Byte 0 was shifted in first, so it sits in the top byte.
                            csb_d      = 1'b1;
                            rd_valid_d = 1'b1;
                            rd_data_d  = {sr_q[7:0], sr_q[15:8], sr_q[23:16], sr_q[31:24]};
                            gap_cnt_d  = '0;
                        end
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt_q     <= '0;
            rise_cnt_q <= '0;
            gap_cnt_q  <= '0;
            sr_q       <= '0;
            sck_q      <= 1'b0;
            csb_q      <= 1'b1;
            dio_o_q    <= 2'b00;
            dio_oe_q   <= 2'b00;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            hcnt_q     <= hcnt_d;
            rise_cnt_q <= rise_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            sr_q       <= sr_d;
            sck_q      <= sck_d;
            csb_q      <= csb_d;
            dio_o_q    <= dio_o_d;
            dio_oe_q   <= dio_oe_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

endmodule

// File: tb/tb_dspi_nor_reader.sv
// tb/tb_dspi_nor_reader.sv - self-checking bench for dspi_nor_reader with a 2-2-2 flash model
module tb_dspi_nor_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_req_w   [2];
    logic [23:0] rd_addr_w  [2];
    logic        rd_ready_w [2];
    logic        rd_valid_w [2];
    logic [31:0] rd_data_w  [2];
    logic        sck_w      [2];
    logic        csb_w      [2];
    logic [1:0]  dio_o_w    [2];
    logic [1:0]  dio_oe_w   [2];
    logic [1:0]  dio_i_w    [2] = '{2'b00, 2'b00};

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int          d;
        logic [31:0] data;
        logic [23:0] addr;
        int          acc;
    } sb_t;
    sb_t sbq[$];

    typedef struct {
        int          d;
        logic [23:0] addr;
        logic [7:0]  xp;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[7];

    logic [7:0]  xp       [2];
    logic [31:0] exp_cur  [2];

    int          f_rise       [2] = '{0, 0};
    logic [31:0] f_sr         [2] = '{32'd0, 32'd0};
    int          f_oe_err     [2] = '{0, 0};
    int          f_last_rises [2] = '{0, 0};
    logic        sck_p        [2] = '{1'b0, 1'b0};
    logic        csb_p        [2] = '{1'b1, 1'b1};
    int          wc           [2] = '{0, 0};
    int          csb_rise_cyc [2] = '{0, 0};
    int          last_gap     [2] = '{0, 0};
    int          rdy_bad      [2] = '{0, 0};
    int          fp;
    logic [23:0] fa;
    logic [7:0]  fb;
    int          found;
    sb_t         e;

    dspi_nor_reader #(.SCK_HALF(2), .CMD(8'hBB), .DUMMY(8), .CSB_IDLE(4)) dut0 (
        .clk(clk), .rst(rst), .rd_req(rd_req_w[0]), .rd_addr(rd_addr_w[0]),
        .rd_ready(rd_ready_w[0]), .rd_valid(rd_valid_w[0]), .rd_data(rd_data_w[0]),
        .sck(sck_w[0]), .csb(csb_w[0]), .dio_o(dio_o_w[0]), .dio_oe(dio_oe_w[0]), .dio_i(dio_i_w[0])
    );

    dspi_nor_reader #(.SCK_HALF(1), .CMD(8'hBB), .DUMMY(8), .CSB_IDLE(4)) dut1 (
        .clk(clk), .rst(rst), .rd_req(rd_req_w[1]), .rd_addr(rd_addr_w[1]),
        .rd_ready(rd_ready_w[1]), .rd_valid(rd_valid_w[1]), .rd_data(rd_data_w[1]),
        .sck(sck_w[1]), .csb(csb_w[1]), .dio_o(dio_o_w[1]), .dio_oe(dio_oe_w[1]), .dio_i(dio_i_w[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Flash model, sck timing monitor and scoreboard, all sampled on the falling clk edge.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++) begin
            if (rst) begin
                wc[g] = 0;
                sbq.delete();
            end else begin
                if (csb_p[g] && !csb_w[g]) begin
                    f_rise[g]   = 0;
                    f_sr[g]     = '0;
                    f_oe_err[g] = 0;
                    last_gap[g] = cyc - csb_rise_cyc[g];
                    wc[g]       = 0;
                end else begin
                    wc[g]++;
                    if (sck_w[g] != sck_p[g]) begin
                        chk($sformatf("sck_half_width dut%0d", g), 64'(wc[g]), (g == 0) ? 64'd2 : 64'd1);
                        wc[g] = 0;
                    end
                end
                if (!csb_w[g] && sck_w[g] && !sck_p[g]) begin
                    if (f_rise[g] < 16) begin
                        if (dio_oe_w[g] !== 2'b11) f_oe_err[g]++;
                        f_sr[g] = {f_sr[g][29:0], dio_o_w[g]};
                    end else if (dio_oe_w[g] !== 2'b00) begin
                        f_oe_err[g]++;
                    end
                    f_rise[g]++;
                end
                if (!csb_w[g] && !sck_w[g] && sck_p[g]) begin
                    fp = f_rise[g] - 24;
                    if (fp >= 0 && fp < 16) begin
                        fa = f_sr[g][23:0] + 24'(fp / 4);
                        fb = fa[7:0] ^ xp[g];
                        dio_i_w[g] = 2'(fb >> (6 - 2 * (fp % 4)));
                    end
                end
                if (!csb_p[g] && csb_w[g]) begin
                    f_last_rises[g] = f_rise[g];
                    csb_rise_cyc[g] = cyc;
                end
                if (!csb_w[g] && rd_ready_w[g]) rdy_bad[g]++;
                if (rd_req_w[g] && rd_ready_w[g]) begin
                    sbq.push_back('{g, exp_cur[g], rd_addr_w[g], cyc + 1});
                end
                if (rd_valid_w[g]) begin
                    found = -1;
                    for (int k = 0; k < sbq.size(); k++) begin
                        if (found < 0 && sbq[k].d == g) found = k;
                    end
                    if (found < 0) begin
                        n_chk++;
                        n_err++;
                        $display("FAIL unexpected_rd_valid dut%0d: got data %h expected no response", g, rd_data_w[g]);
                    end else begin
                        e = sbq[found];
                        sbq.delete(found);
                        chk($sformatf("rd_data dut%0d", g), 64'(rd_data_w[g]), 64'(e.data));
                        chk($sformatf("latency dut%0d", g), 64'(cyc - e.acc), (g == 0) ? 64'd161 : 64'd81);
                        chk($sformatf("cmd_sent dut%0d", g), 64'(f_sr[g][31:24]), 64'hBB);
                        chk($sformatf("addr_sent dut%0d", g), 64'(f_sr[g][23:0]), 64'(e.addr));
                        chk($sformatf("sck_rises dut%0d", g), 64'(f_last_rises[g]), 64'd40);
                        chk($sformatf("dio_oe_errs dut%0d", g), 64'(f_oe_err[g]), 64'd0);
                    end
                end
            end
            sck_p[g] = sck_w[g];
            csb_p[g] = csb_w[g];
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic issue(input int d, input logic [23:0] a, input logic [31:0] ex);
        logic acc;
        int   k;
        bit   done;
        rd_addr_w[d] = a;
        exp_cur[d]   = ex;
        rd_req_w[d]  = 1'b1;
        done = 0;
        k    = 0;
        while (!done && k < 400) begin
            acc = rd_ready_w[d];
            @(posedge clk);
            #1;
            if (acc) done = 1;
            k++;
        end
        if (!done) begin
            n_chk++;
            n_err++;
            $display("FAIL accept_timeout dut%0d: got no rd_ready expected accept within 400 clks", d);
        end
    endtask

    task automatic drain(input int d);
        int  k;
        bit  busy;
        busy = 1;
        k    = 0;
        while (busy && k < 400) begin
            @(posedge clk);
            #1;
            busy = 0;
            for (int j = 0; j < sbq.size(); j++) if (sbq[j].d == d) busy = 1;
            k++;
        end
        if (busy) begin
            n_chk++;
            n_err++;
            $display("FAIL response_timeout dut%0d: got no rd_valid expected one within 400 clks", d);
        end
    endtask

    initial begin
        int  b0;
        bit  hit;
        rst = 1'b1;
        for (int g = 0; g < 2; g++) begin
            rd_req_w[g]  = 1'b0;
            rd_addr_w[g] = '0;
            xp[g]        = '0;
            exp_cur[g]   = '0;
        end
        vecs[0] = '{0, 24'h000000, 8'h00, 32'h03020100};
        vecs[1] = '{0, 24'h0000FD, 8'hA5, 32'hA55A5B58};
        vecs[2] = '{0, 24'hFFFFFE, 8'h3C, 32'h3D3CC3C2};
        vecs[3] = '{0, 24'h123457, 8'h00, 32'h5A595857};
        vecs[4] = '{1, 24'h000000, 8'h00, 32'h03020100};
        vecs[5] = '{1, 24'h0000FD, 8'hA5, 32'hA55A5B58};
        vecs[6] = '{1, 24'hABCDEF, 8'hFF, 32'h0D0E0F10};

        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) begin
            chk($sformatf("reset_csb dut%0d", g), 64'(csb_w[g]), 64'd1);
            chk($sformatf("reset_sck dut%0d", g), 64'(sck_w[g]), 64'd0);
            chk($sformatf("reset_dio_oe dut%0d", g), 64'(dio_oe_w[g]), 64'd0);
            chk($sformatf("reset_dio_o dut%0d", g), 64'(dio_o_w[g]), 64'd0);
            chk($sformatf("reset_rd_valid dut%0d", g), 64'(rd_valid_w[g]), 64'd0);
            chk($sformatf("reset_rd_data dut%0d", g), 64'(rd_data_w[g]), 64'd0);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int g = 0; g < 2; g++) chk($sformatf("reset_rd_ready dut%0d", g), 64'(rd_ready_w[g]), 64'd1);

        for (int i = 0; i < 7; i++) begin
            xp[vecs[i].d] = vecs[i].xp;
            issue(vecs[i].d, vecs[i].addr, vecs[i].exp);
            rd_req_w[vecs[i].d] = 1'b0;
            drain(vecs[i].d);
        end

        // Back-to-back with rd_req held high
        xp[0] = 8'h00;
        b0 = rdy_bad[0];
        issue(0, 24'h000010, 32'h13121110);
        issue(0, 24'h000020, 32'h23222120);
        rd_req_w[0] = 1'b0;
        drain(0);
        chk("b2b_csb_high_clks", 64'(last_gap[0]), 64'd5);
        chk("b2b_ready_low_while_busy", 64'(rdy_bad[0] - b0), 64'd0);

        // Reset after the 5th data rising edge
        issue(0, 24'h000080, 32'h83828180);
        rd_req_w[0] = 1'b0;
        hit = 0;
        for (int k = 0; k < 400 && !hit; k++) begin
            @(negedge clk);
            #1;
            if (f_rise[0] == 29) hit = 1;
        end
        if (!hit) begin
            n_chk++;
            n_err++;
            $display("FAIL reset_point_timeout: got %0d rises expected 29", f_rise[0]);
        end
        rst = 1'b1;
        #1;
        chk("midreset_csb", 64'(csb_w[0]), 64'd1);
        chk("midreset_sck", 64'(sck_w[0]), 64'd0);
        chk("midreset_dio_oe", 64'(dio_oe_w[0]), 64'd0);
        chk("midreset_rd_valid", 64'(rd_valid_w[0]), 64'd0);
        chk("midreset_rd_data", 64'(rd_data_w[0]), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(0, 24'h000040, 32'h43424140);
        rd_req_w[0] = 1'b0;
        drain(0);

        repeat (10) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected completion within 1 ms");
        $fatal(1, "watchdog");
    end

endmodule
